// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, keeps at most one instruction-memory read
// outstanding, and hands each returned word (with its PC and PC+4) to decode through
// a one-entry valid/ready output buffer. Redirects from execute override everything
// else on the same edge; a response whose request was overtaken by a redirect is dropped.
module instruction_fetch #(
    parameter int unsigned      XLEN      = 64,
    parameter logic [XLEN-1:0]  RESET_PC  = 64'h0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    // instruction memory request channel
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    // instruction memory response channel
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rdata,
    // redirect from execute
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    // decode interface
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instruction,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4
);

    // FETCH: request may be presented; WAIT: one read in flight; HOLD: word buffered for decode
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t          state_reg;
    state_t          state_next;

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] inflight_pc_reg;
    logic [XLEN-1:0] inflight_pc_next;
    logic            drop_reg;
    logic            drop_next;

    logic            id_valid_reg;
    logic            id_valid_next;
    logic [31:0]     id_instruction_reg;
    logic [31:0]     id_instruction_next;
    logic [XLEN-1:0] id_pc_reg;
    logic [XLEN-1:0] id_pc_next;
    logic [XLEN-1:0] id_pc_plus4_reg;
    logic [XLEN-1:0] id_pc_plus4_next;

    logic            req_valid_comb;
    logic [XLEN-1:0] redirect_target;

    // Redirect targets are always word aligned; the low two bits are simply discarded.
    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // PC, in-flight bookkeeping and the decode output buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg             <= RESET_PC;
            inflight_pc_reg    <= RESET_PC;
            drop_reg           <= 1'b0;
            id_valid_reg       <= 1'b0;
            id_instruction_reg <= NOP_INSTR;
            id_pc_reg          <= RESET_PC;
            id_pc_plus4_reg    <= RESET_PC + PC_STEP;
        end else begin
            pc_reg             <= pc_next;
            inflight_pc_reg    <= inflight_pc_next;
            drop_reg           <= drop_next;
            id_valid_reg       <= id_valid_next;
            id_instruction_reg <= id_instruction_next;
            id_pc_reg          <= id_pc_next;
            id_pc_plus4_reg    <= id_pc_plus4_next;
        end
    end

    // Next-state and datapath updates; a redirect takes priority in every state.
    always_comb begin
        state_next          = state_reg;
        pc_next             = pc_reg;
        inflight_pc_next    = inflight_pc_reg;
        drop_next           = drop_reg;
        id_valid_next       = id_valid_reg;
        id_instruction_next = id_instruction_reg;
        id_pc_next          = id_pc_reg;
        id_pc_plus4_next    = id_pc_plus4_reg;
        req_valid_comb      = 1'b0;

        case (state_reg)
            S_FETCH: begin
                // Suppress the request while redirecting so the stale PC never reaches memory.
                req_valid_comb = !redirect_valid;
                if (redirect_valid) begin
                    pc_next = redirect_target;
                end else if (imem_req_ready) begin
                    inflight_pc_next = pc_reg;
                    pc_next          = pc_reg + PC_STEP;
                    state_next       = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                    if (imem_rsp_valid) begin
                        // The response landing now belongs to the old path: discard it.
                        drop_next  = 1'b0;
                        state_next = S_FETCH;
                    end else begin
                        // Remember to throw away the response that is still coming.
                        drop_next = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop_reg) begin
                        drop_next  = 1'b0;
                        state_next = S_FETCH;
                    end else begin
                        id_valid_next       = 1'b1;
                        id_instruction_next = imem_rdata;
                        id_pc_next          = inflight_pc_reg;
                        id_pc_plus4_next    = inflight_pc_reg + PC_STEP;
                        state_next          = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    // Squash the buffered word even if decode is ready this cycle.
                    id_valid_next       = 1'b0;
                    id_instruction_next = NOP_INSTR;
                    pc_next             = redirect_target;
                    state_next          = S_FETCH;
                end else if (id_ready) begin
                    id_valid_next       = 1'b0;
                    id_instruction_next = NOP_INSTR;
                    state_next          = S_FETCH;
                end
            end

            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Reset forces the request low without waiting for a clock edge.
    assign imem_req_valid = req_valid_comb & ~reset;
    assign imem_addr      = pc_reg;
    assign id_valid       = id_valid_reg;
    assign id_instruction = id_instruction_reg;
    assign id_pc          = id_pc_reg;
    assign id_pc_plus4    = id_pc_plus4_reg;

endmodule
